// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. It holds the program counter, drives it into a
// combinational instruction ROM, and registers each returned instruction into
// a single output slot that the decoder drains with a valid/ready handshake.
// Control transfers (BRZ, opcode 3'b110; JMP, opcode 3'b111) are resolved
// here. Their source register rsA is read through a dedicated register-file
// port, so the decoder never has to redirect the PC.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   instr_address  ROM address; always the current PC
//   instruction    ROM read data, valid in the same cycle
//   instr_out      registered instruction offered to the decoder
//   instr_pc       address that instr_out was fetched from
//   instr_valid    instr_out holds an instruction not yet consumed
//   instr_ready    decoder takes instr_out at the next edge
//   rs_a_addr      register-file read address (branch rsA), 0 when idle
//   reg_a_data     register-file read data for rs_a_addr
//   reg_a_ready    reg_a_data is free of pending writes and may be used
//   resolving      high while a branch/jump target is being resolved
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [BUS_WIDTH-1:0] instr_address,
    input  logic [BUS_WIDTH-1:0] instruction,
    output logic [BUS_WIDTH-1:0] instr_out,
    output logic [BUS_WIDTH-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [2:0]           rs_a_addr,
    input  logic [BUS_WIDTH-1:0] reg_a_data,
    input  logic                 reg_a_ready,
    output logic                 resolving
);

    localparam logic [2:0]           OP_BRZ = 3'b110;
    localparam logic [2:0]           OP_JMP = 3'b111;
    localparam logic [BUS_WIDTH-1:0] PC_INC = 1;

    typedef enum logic {
        FETCH   = 1'b0,
        RESOLVE = 1'b1
    } state_t;

    // Architectural and slot state.
    state_t               state_q,     state_d;
    logic [BUS_WIDTH-1:0] pc_q,        pc_d;
    logic [BUS_WIDTH-1:0] instr_out_q, instr_out_d;
    logic [BUS_WIDTH-1:0] instr_pc_q,  instr_pc_d;
    logic                 valid_q,     valid_d;

    // Captured branch fields. Only the bits that resolution needs are kept.
    logic                 br_jmp_q,    br_jmp_d;
    logic [2:0]           br_rs_q,     br_rs_d;
    logic [5:0]           br_off_q,    br_off_d;

    logic                 slot_free;

    // Opcode field of an instruction word.
    function automatic logic [2:0] opcode(input logic [BUS_WIDTH-1:0] ins);
        return ins[BUS_WIDTH-1 -: 3];
    endfunction

    function automatic logic is_branch(input logic [BUS_WIDTH-1:0] ins);
        return (opcode(ins) == OP_BRZ) || (opcode(ins) == OP_JMP);
    endfunction

    // 6-bit two's-complement branch displacement, sign-extended to PC width.
    function automatic logic [BUS_WIDTH-1:0] sext_off(input logic [5:0] raw);
        return {{(BUS_WIDTH-6){raw[5]}}, raw};
    endfunction

    // Next PC once rsA is readable. The PC still points at the branch itself
    // while resolving, so BRZ offsets are relative to the branch address.
    // All arithmetic wraps modulo 2^BUS_WIDTH.
    function automatic logic [BUS_WIDTH-1:0] resolve_target(
        input logic                 is_jmp,
        input logic [5:0]           off,
        input logic [BUS_WIDTH-1:0] pc,
        input logic [BUS_WIDTH-1:0] rdata
    );
        logic [BUS_WIDTH-1:0] target;
        if (is_jmp) begin
            target = rdata;
        end else if (rdata == '0) begin
            target = pc + sext_off(off);
        end else begin
            target = pc + PC_INC;
        end
        return target;
    endfunction

    // The slot can accept a new instruction when it is empty, or when the
    // decoder drains it at the same edge (consume-and-refill).
    assign slot_free = !valid_q || instr_ready;

    // Next-state and slot logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_out_d = instr_out_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        br_jmp_d    = br_jmp_q;
        br_rs_d     = br_rs_q;
        br_off_d    = br_off_q;

        case (state_q)
            FETCH: begin
                if (slot_free) begin
                    instr_out_d = instruction;
                    instr_pc_d  = pc_q;
                    valid_d     = 1'b1;
                    if (is_branch(instruction)) begin
                        // PC stays on the branch; the ROM is idle until the
                        // target is known.
                        br_jmp_d = (opcode(instruction) == OP_JMP);
                        br_rs_d  = instruction[5:3];
                        br_off_d = {instruction[8:6], instruction[2:0]};
                        state_d  = RESOLVE;
                    end else begin
                        pc_d = pc_q + PC_INC;
                    end
                end
            end

            RESOLVE: begin
                // The branch itself still sits in the slot and may be
                // consumed; nothing refills it until fetching resumes.
                if (instr_ready) begin
                    valid_d = 1'b0;
                end
                if (reg_a_ready) begin
                    pc_d    = resolve_target(br_jmp_q, br_off_q, pc_q, reg_a_data);
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Control and slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            instr_out_q <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_out_q <= instr_out_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
        end
    end

    // Branch capture; only meaningful while RESOLVE, so no reset needed.
    always_ff @(posedge clk) begin
        br_jmp_q <= br_jmp_d;
        br_rs_q  <= br_rs_d;
        br_off_q <= br_off_d;
    end

    assign instr_address = pc_q;
    assign instr_out     = instr_out_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = valid_q;
    assign resolving     = (state_q == RESOLVE);
    assign rs_a_addr     = (state_q == RESOLVE) ? br_rs_q : 3'd0;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] instr_address;
    logic [15:0] instruction;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  rs_a_addr;
    logic [15:0] reg_a_data;
    logic        reg_a_ready;
    logic        resolving;

    logic [15:0] mem  [0:65535];
    logic [15:0] regs [0:7];

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.BUS_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_address(instr_address),
        .instruction  (instruction),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .rs_a_addr    (rs_a_addr),
        .reg_a_data   (reg_a_data),
        .reg_a_ready  (reg_a_ready),
        .resolving    (resolving)
    );

    // Combinational ROM and register-file read port.
    assign instruction = mem[instr_address];
    assign reg_a_data  = regs[rs_a_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Non-branch filler word: opcode 000, low bits tag the address.
    function automatic logic [15:0] filler(input logic [15:0] a);
        return {3'b000, a[12:0]};
    endfunction

    // Architectural successor of the instruction at pc.
    function automatic logic [15:0] arch_next(input logic [15:0] pc, input logic [15:0] ins);
        logic [15:0] off;
        logic [15:0] rv;
        off = {{10{ins[8]}}, ins[8:6], ins[2:0]};
        rv  = regs[ins[5:3]];
        case (ins[15:13])
            3'b111:  return rv;
            3'b110:  return (rv == 16'd0) ? pc + off : pc + 16'd1;
            default: return pc + 16'd1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_default();
        for (int a = 0; a < 65536; a++) mem[a] = filler(16'(a));
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        reg_a_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 16'd0 || instr_pc !== 16'd0) begin
            failures++;
            $display("FAIL reset_slot valid=%b out=%h pc=%h expected 0/0000/0000", instr_valid, instr_out, instr_pc);
        end
        checks++;
        if (instr_address !== 16'd0 || rs_a_addr !== 3'd0 || resolving !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl addr=%h rs=%0d resolving=%b expected 0000/0/0", instr_address, rs_a_addr, resolving);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (instr_address !== 16'(i)) begin
                failures++;
                $display("FAIL stream_addr got=%h expected=%h", instr_address, 16'(i));
            end
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== filler(16'(i)) || instr_pc !== 16'(i)) begin
                failures++;
                $display("FAIL stream_slot valid=%b out=%h pc=%h expected 1/%h/%h", instr_valid, instr_out, instr_pc, filler(16'(i)), 16'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== filler(16'd3) || instr_pc !== 16'd3 || instr_address !== 16'd4) begin
                failures++;
                $display("FAIL stall_hold valid=%b out=%h pc=%h addr=%h expected 1/%h/0003/0004", instr_valid, instr_out, instr_pc, instr_address, filler(16'd3));
            end
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(3 + k) || instr_out !== filler(16'(3 + k))) begin
                failures++;
                $display("FAIL stall_release valid=%b pc=%h out=%h expected 1/%h/%h", instr_valid, instr_pc, instr_out, 16'(3 + k), filler(16'(3 + k)));
            end
            tick();
        end
    endtask

    task automatic test_brz();
        logic [15:0] exp_next;
        fill_default();
        mem[22] = 16'b110_0000_000_010_010;
        instr_ready = 1'b1;
        reg_a_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            regs[2]  = (c == 0) ? 16'd0 : 16'd5;
            exp_next = (c == 0) ? 16'd24 : 16'd23;
            do_reset();
            repeat (22) tick();
            checks++;
            if (instr_address !== 16'd22) begin
                failures++;
                $display("FAIL brz_reach addr=%h expected=0016", instr_address);
            end
            tick();
            checks++;
            if (resolving !== 1'b1 || rs_a_addr !== 3'd2 || instr_pc !== 16'd22 || instr_out !== 16'hC012 || instr_address !== 16'd22) begin
                failures++;
                $display("FAIL brz_resolve res=%b rs=%0d pc=%h out=%h addr=%h expected 1/2/0016/c012/0016", resolving, rs_a_addr, instr_pc, instr_out, instr_address);
            end
            tick();
            checks++;
            if (resolving !== 1'b0 || rs_a_addr !== 3'd0 || instr_address !== exp_next || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL brz_target res=%b rs=%0d addr=%h valid=%b expected 0/0/%h/0", resolving, rs_a_addr, instr_address, instr_valid, exp_next);
            end
            tick();
            checks++;
            if (instr_pc !== exp_next || instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL brz_refetch pc=%h valid=%b expected %h/1", instr_pc, instr_valid, exp_next);
            end
        end
        mem[22] = filler(16'd22);
    endtask

    task automatic test_brz_wrap();
        instr_ready = 1'b1;
        reg_a_ready = 1'b1;
        regs[5] = 16'd0;
        mem[1] = 16'b110_0000_111_101_111;
        do_reset();
        tick();
        tick();
        checks++;
        if (resolving !== 1'b1 || rs_a_addr !== 3'd5) begin
            failures++;
            $display("FAIL wrap_m1_resolve res=%b rs=%0d expected 1/5", resolving, rs_a_addr);
        end
        tick();
        checks++;
        if (instr_address !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_m1_addr got=%h expected=0000", instr_address);
        end
        mem[1] = 16'b110_0000_111_101_110;
        do_reset();
        repeat (3) tick();
        checks++;
        if (instr_address !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_m2_addr got=%h expected=ffff", instr_address);
        end
        tick();
        checks++;
        if (instr_address !== 16'h0000 || instr_pc !== 16'hFFFF || instr_out !== filler(16'hFFFF)) begin
            failures++;
            $display("FAIL wrap_inc addr=%h pc=%h out=%h expected 0000/ffff/%h", instr_address, instr_pc, instr_out, filler(16'hFFFF));
        end
        mem[1] = filler(16'd1);
    endtask

    task automatic test_jmp_stall();
        mem[23] = 16'hE018;
        regs[3] = 16'h0100;
        instr_ready = 1'b1;
        reg_a_ready = 1'b0;
        do_reset();
        repeat (23) tick();
        checks++;
        if (instr_address !== 16'd23) begin
            failures++;
            $display("FAIL jmp_reach addr=%h expected=0017", instr_address);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) reg_a_ready = 1'b1;
            if (k == 0) tick();
            checks++;
            if (resolving !== 1'b1 || rs_a_addr !== 3'd3 || instr_address !== 16'd23) begin
                failures++;
                $display("FAIL jmp_hold cycle=%0d res=%b rs=%0d addr=%h expected 1/3/0017", k, resolving, rs_a_addr, instr_address);
            end
            tick();
        end
        checks++;
        if (resolving !== 1'b0 || instr_address !== 16'h0100) begin
            failures++;
            $display("FAIL jmp_target res=%b addr=%h expected 0/0100", resolving, instr_address);
        end
        mem[23] = filler(16'd23);
    endtask

    task automatic test_reset_in_resolve();
        mem[23] = 16'hE018;
        instr_ready = 1'b1;
        reg_a_ready = 1'b0;
        do_reset();
        repeat (24) tick();
        instr_ready = 1'b0;
        tick();
        checks++;
        if (resolving !== 1'b1 || instr_valid !== 1'b1 || instr_out !== 16'hE018) begin
            failures++;
            $display("FAIL rr_pre res=%b valid=%b out=%h expected 1/1/e018", resolving, instr_valid, instr_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (instr_address !== 16'd0 || instr_valid !== 1'b0 || resolving !== 1'b0 || rs_a_addr !== 3'd0 || instr_out !== 16'd0) begin
            failures++;
            $display("FAIL rr_reset addr=%h valid=%b res=%b rs=%0d out=%h expected 0000/0/0/0/0000", instr_address, instr_valid, resolving, rs_a_addr, instr_out);
        end
        rst = 1'b0;
        instr_ready = 1'b1;
        reg_a_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'd0 || instr_address !== 16'd1) begin
            failures++;
            $display("FAIL rr_restart valid=%b pc=%h addr=%h expected 1/0000/0001", instr_valid, instr_pc, instr_address);
        end
        mem[23] = filler(16'd23);
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        int consumed;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int r = 0; r < 8; r++) regs[r] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
        instr_ready = 1'b1;
        reg_a_ready = 1'b1;
        do_reset();
        exp_pc   = 16'd0;
        consumed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!resolving) begin
                checks++;
                if (rs_a_addr !== 3'd0) begin
                    failures++;
                    $display("FAIL rnd_rs_idle cycle=%0d rs=%0d expected 0", cyc, rs_a_addr);
                end
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            reg_a_ready = ($urandom_range(0, 2) != 0);
            if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr_out !== mem[exp_pc]) begin
                    failures++;
                    $display("FAIL rnd_stream cycle=%0d pc=%h out=%h expected %h/%h", cyc, instr_pc, instr_out, exp_pc, mem[exp_pc]);
                end
                exp_pc = arch_next(exp_pc, mem[exp_pc]);
                consumed++;
            end
            tick();
        end
        checks++;
        if (consumed < 500) begin
            failures++;
            $display("FAIL rnd_progress consumed=%0d expected at least 500", consumed);
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_ready = 1'b0;
        reg_a_ready = 1'b1;
        for (int r = 0; r < 8; r++) regs[r] = 16'd0;
        fill_default();
        test_reset();
        test_stream();
        test_backpressure();
        test_brz();
        test_brz_wrap();
        test_jmp_stall();
        test_reset_in_resolve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit; the initiator side of the combinational instruction ROM.
- Holds the program counter and drives instr_address into the ROM.
- Registers the returned 16-bit instruction into an output slot for the decoder, using a valid/ready handshake.
- Resolves BRZ (opcode 3'b110) and JMP (opcode 3'b111) itself by reading register rsA through a dedicated register-file read port.

Parameters:
- BUS_WIDTH, 16, width of the instruction word, the program counter and register data.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr_address  output  BUS_WIDTH  ROM address; always equals the current PC
- instruction  input  BUS_WIDTH  ROM data; combinational, valid in the same cycle
- instr_out  output  BUS_WIDTH  registered instruction presented to the decoder
- instr_pc  output  BUS_WIDTH  address that instr_out was fetched from
- instr_valid  output  1  instr_out holds an unconsumed instruction
- instr_ready  input  1  decoder accepts instr_out this cycle
- rs_a_addr  output  3  register-file read address; equals the captured branch's instr[5:3]
- reg_a_data  input  BUS_WIDTH  register-file read data for rs_a_addr, combinational
- reg_a_ready  input  1  no pending write to rs_a_addr; reg_a_data may be used
- resolving  output  1  high while in RESOLVE

Behaviour:
Reset:
- pc=0, state=FETCH.
- instr_valid=0, instr_out=0, instr_pc=0, rs_a_addr=0, resolving=0.
- Reset wins over all other inputs, including mid-RESOLVE.

Slot rule:
- The slot is free when instr_valid=0 OR instr_ready=1.
- Consuming the slot without a new load clears instr_valid on the next edge.

FETCH state:
- If the slot is free: instr_out<=instruction, instr_pc<=pc, instr_valid<=1.
  - If instruction[15:13] is 3'b110 or 3'b111: save it in br_reg, keep pc, go to RESOLVE.
  - Otherwise: pc<=pc+1.
- If the slot is not free: pc, instr_out and instr_pc hold. This is a stall with no lost or duplicated instruction.
- Throughput is 1 instruction/cycle while instr_ready=1.

RESOLVE state:
- resolving=1 and rs_a_addr=br_reg[5:3]. The ROM is not sampled.
- The branch instruction stays in the slot and follows normal handshake rules; it may be consumed during RESOLVE.
- While reg_a_ready=0: stay in RESOLVE.
- When reg_a_ready=1, compute the next pc and return to FETCH the next cycle:
  - JMP: pc<=reg_a_data.
  - BRZ: off=sign-extend of {br_reg[8:6], br_reg[2:0]}, 6-bit two's complement, range -32..+31. pc<=(reg_a_data==0) ? pc+off : pc+1.
  - pc in this cycle is still the branch's own address.

Arithmetic and timing:
- All PC arithmetic is modulo 2^16. 0xFFFF+1 gives 0x0000; 0x0001+(-2) gives 0xFFFF.
- Branch penalty is exactly 1 bubble cycle when reg_a_ready=1, plus 1 cycle per cycle reg_a_ready is low.

Simultaneous events:
- instr_ready=1 together with a FETCH load is consume-and-refill: instr_valid stays 1.
- A branch fetched while the previous instruction is consumed in the same cycle is legal.

Miscellaneous:
- Opcodes other than 110/111 are passed through without decode, including illegal ones.
- rs_a_addr is 0 outside RESOLVE.

Test Plan:
1. Reset, then instr_ready=1 with ROM = LDI sequence at addresses 0..7 -> instr_address goes 0,1,...,7 on consecutive cycles; instr_out/instr_pc match one cycle later; instr_valid=1 from the first edge after reset.
2. Backpressure: drop instr_ready for 3 cycles at pc=4 -> instr_out=mem[3] and instr_pc=3 are held; instr_address stays 4; after release the decoder sees 3, 4, 5 with nothing dropped or duplicated.
3. BRZ at address 22 (16'b110_0000_000_010_010, off=+2) with reg_a_data=0 -> rs_a_addr=2 and resolving=1 for one cycle; next fetch address is 24. Repeat with reg_a_data=5 -> next fetch address is 23.
4. BRZ with off bits 111/111 (-1) at address 0x0001 with reg_a_data=0 -> next fetch address 0x0000. BRZ with off=-2 at address 0x0001 -> next fetch address 0xFFFF. Straight-line fetch at 0xFFFF -> next fetch address 0x0000.
5. JMP at address 23 with reg_a_data=16'h0100 and reg_a_ready held low for 2 cycles -> resolving stays high for 3 cycles; next fetch address is 0x0100.
6. Assert rst during RESOLVE with instr_valid=1 -> after the next edge: pc=0, instr_valid=0, resolving=0, state=FETCH; fetching restarts at address 0.
